pipeline_sched: RTL and testbench

//  Hazard and stage scheduler for the MIPS 5-stage pipeline (IF/ID/EXE/MEM/WB).

---
 rtl/pipeline_sched_pkg.sv | 14 +
 rtl/pipeline_sched_fwd_unit.sv | 39 +++
 rtl/pipeline_sched.sv | 153 +++++++++++++++
 tb/tb_pipeline_sched.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_sched_pkg.sv
// Shared encodings for the pipeline scheduler: forwarding selects and FSM states.
package pipeline_sched_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;

    typedef enum logic [1:0] {
        SCHED_RUN      = 2'd0,
        SCHED_INV_WAIT = 2'd1,
        SCHED_FLUSH    = 2'd2
    } sched_state_e;

endpackage

// File: rtl/pipeline_sched_fwd_unit.sv
// Per-operand RAW match against EXE/MEM: forwarding select plus stall request.
module fwd_unit
    import pipeline_sched_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic [4:0] src_addr,
    input  logic       src_used,
    input  logic [4:0] exe_wb_addr,
    input  logic       exe_wb_wen,
    input  logic       exe_mem_ren,
    input  logic [4:0] mem_wb_addr,
    input  logic       mem_wb_wen,
    output logic [1:0] fwd_sel,
    output logic       raw_hit
);

    logic exe_hit;
    logic mem_hit;

    always_comb begin
        exe_hit = src_used && exe_wb_wen && (exe_wb_addr != 5'd0) && (exe_wb_addr == src_addr);
        mem_hit = src_used && mem_wb_wen && (mem_wb_addr != 5'd0) && (mem_wb_addr == src_addr);
        fwd_sel = FWD_REG;
        raw_hit = 1'b0;
        if (FWD_EN != 0) begin
            // A load in EXE has no result yet; that case stalls instead of forwarding.
            if (exe_hit && !exe_mem_ren) begin
                fwd_sel = FWD_EXE;
            end else if (mem_hit) begin
                fwd_sel = FWD_MEM;
            end
            raw_hit = exe_hit && exe_mem_ren;
        end else begin
            raw_hit = exe_hit || mem_hit;
        end
    end

endmodule

// File: rtl/pipeline_sched.sv
// Stage enable/bubble scheduler with forwarding, cache-invalidate wait and exception flush.
//   state          | meaning
//   SCHED_RUN      | normal issue; exception, stall, invalidate and hazard arbitration
//   SCHED_INV_WAIT | pipeline frozen until inv_done or timeout
//   SCHED_FLUSH    | bubbles into ID/EXE/MEM while the exception target is fetched
module pipeline_sched
    import pipeline_sched_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int INV_TIMEOUT = 255,
    parameter int FLUSH_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic [4:0] exe_wb_addr,
    input  logic       exe_wb_wen,
    input  logic       exe_mem_ren,
    input  logic [4:0] mem_wb_addr,
    input  logic       mem_wb_wen,
    input  logic       mem_inv_req,
    input  logic       inv_done,
    input  logic       ic_stall,
    input  logic       dc_stall,
    input  logic       exc_req,
    output logic       if_en,
    output logic       id_en,
    output logic       exe_en,
    output logic       mem_en,
    output logic       wb_en,
    output logic       id_rst,
    output logic       exe_rst,
    output logic       mem_rst,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       inv_start,
    output logic       inv_err,
    output logic       pc_exc_sel
);

    sched_state_e state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [4:0]   en_v;
    logic [2:0]   bub_v;
    logic [1:0]   fwd_a_sel, fwd_b_sel;
    logic         hit_a, hit_b;

    fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rs (
        .src_addr    (id_rs_addr),
        .src_used    (id_rs_used),
        .exe_wb_addr (exe_wb_addr),
        .exe_wb_wen  (exe_wb_wen),
        .exe_mem_ren (exe_mem_ren),
        .mem_wb_addr (mem_wb_addr),
        .mem_wb_wen  (mem_wb_wen),
        .fwd_sel     (fwd_a_sel),
        .raw_hit     (hit_a)
    );

    fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rt (
        .src_addr    (id_rt_addr),
        .src_used    (id_rt_used),
        .exe_wb_addr (exe_wb_addr),
        .exe_wb_wen  (exe_wb_wen),
        .exe_mem_ren (exe_mem_ren),
        .mem_wb_addr (mem_wb_addr),
        .mem_wb_wen  (mem_wb_wen),
        .fwd_sel     (fwd_b_sel),
        .raw_hit     (hit_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCHED_RUN;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // en_v = {if, id, exe, mem, wb}; bub_v = {id, exe, mem}
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        en_v       = 5'b00000;
        bub_v      = 3'b000;
        inv_start  = 1'b0;
        inv_err    = 1'b0;
        pc_exc_sel = 1'b0;
        if (rst) begin
            bub_v = 3'b111;
        end else begin
            case (state_q)
                SCHED_RUN: begin
                    if (exc_req) begin
                        pc_exc_sel = 1'b1;
                        en_v       = 5'b10001;
                        bub_v      = 3'b111;
                        state_d    = SCHED_FLUSH;
                        cnt_d      = 8'(FLUSH_CYC - 1);
                    end else if (ic_stall || dc_stall) begin
                        en_v = 5'b00000;
                    end else if (mem_inv_req) begin
                        inv_start = 1'b1;
                        state_d   = SCHED_INV_WAIT;
                        cnt_d     = 8'd0;
                    end else if (hit_a || hit_b) begin
                        en_v  = 5'b00111;
                        bub_v = 3'b010;
                    end else begin
                        en_v = 5'b11111;
                    end
                end
                SCHED_INV_WAIT: begin
                    cnt_d = cnt_q + 8'd1;
                    if (inv_done) begin
                        en_v    = 5'b11111;
                        state_d = SCHED_RUN;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == 8'(INV_TIMEOUT)) begin
                        inv_err = 1'b1;
                        en_v    = 5'b11111;
                        state_d = SCHED_RUN;
                        cnt_d   = 8'd0;
                    end
                end
                SCHED_FLUSH: begin
                    en_v  = 5'b00001;
                    bub_v = 3'b111;
                    if (cnt_q == 8'd0) begin
                        state_d = SCHED_RUN;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = SCHED_RUN;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign {if_en, id_en, exe_en, mem_en, wb_en} = en_v;
    assign {id_rst, exe_rst, mem_rst}            = bub_v;
    assign fwd_a = rst ? FWD_REG : fwd_a_sel;
    assign fwd_b = rst ? FWD_REG : fwd_b_sel;

endmodule

// File: tb/tb_pipeline_sched.sv
// Directed scoreboard bench for pipeline_sched with default parameters.
module tb_pipeline_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs_addr, id_rt_addr;
    logic       id_rs_used, id_rt_used;
    logic [4:0] exe_wb_addr;
    logic       exe_wb_wen, exe_mem_ren;
    logic [4:0] mem_wb_addr;
    logic       mem_wb_wen;
    logic       mem_inv_req, inv_done, ic_stall, dc_stall, exc_req;
    logic       if_en, id_en, exe_en, mem_en, wb_en;
    logic       id_rst, exe_rst, mem_rst;
    logic [1:0] fwd_a, fwd_b;
    logic       inv_start, inv_err, pc_exc_sel;

    int vectors     = 0;
    int miscompares = 0;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_sched dut (
        .clk(clk), .rst(rst),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .exe_wb_addr(exe_wb_addr), .exe_wb_wen(exe_wb_wen), .exe_mem_ren(exe_mem_ren),
        .mem_wb_addr(mem_wb_addr), .mem_wb_wen(mem_wb_wen),
        .mem_inv_req(mem_inv_req), .inv_done(inv_done),
        .ic_stall(ic_stall), .dc_stall(dc_stall), .exc_req(exc_req),
        .if_en(if_en), .id_en(id_en), .exe_en(exe_en), .mem_en(mem_en), .wb_en(wb_en),
        .id_rst(id_rst), .exe_rst(exe_rst), .mem_rst(mem_rst),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .inv_start(inv_start), .inv_err(inv_err), .pc_exc_sel(pc_exc_sel)
    );

    // {en(if,id,exe,mem,wb), rst(id,exe,mem), fwd_a, fwd_b, inv_start, inv_err, pc_exc_sel}
    function automatic logic [14:0] mk(input logic [4:0] en, input logic [2:0] bub,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic st, input logic er, input logic pc);
        return {en, bub, fa, fb, st, er, pc};
    endfunction

    task automatic idle_inputs();
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        exe_wb_addr = 5'd0; exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        mem_wb_addr = 5'd0; mem_wb_wen = 1'b0;
        mem_inv_req = 1'b0; inv_done = 1'b0; ic_stall = 1'b0; dc_stall = 1'b0; exc_req = 1'b0;
    endtask

    task automatic step(input logic [14:0] expv, input string tag);
        logic [14:0] obs;
        logic [14:0] e;
        exp_q.push_back(expv);
        @(negedge clk);
        obs = {if_en, id_en, exe_en, mem_en, wb_en, id_rst, exe_rst, mem_rst,
               fwd_a, fwd_b, inv_start, inv_err, pc_exc_sel};
        e = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;

    initial begin
        idle_inputs();
        rst = 1'b1;
        // Live EXE match during reset must not leak onto fwd_a.
        id_rs_addr = 5'd3; id_rs_used = 1'b1; exe_wb_addr = 5'd3; exe_wb_wen = 1'b1;
        step(mk(EN_NONE, 3'b111, 2'd0, 2'd0, 0, 0, 0), "reset");
        rst = 1'b0;
        idle_inputs();
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_idle");

        // lw $2 in EXE, ID reads $2
        id_rs_addr = 5'd2; id_rs_used = 1'b1; id_rt_addr = 5'd5; id_rt_used = 1'b1;
        exe_wb_addr = 5'd2; exe_wb_wen = 1'b1; exe_mem_ren = 1'b1;
        step(mk(5'b00111, 3'b010, 2'd0, 2'd0, 0, 0, 0), "load_use_rs");
        exe_wb_addr = 5'd0; exe_wb_wen = 1'b0; exe_mem_ren = 1'b0;
        mem_wb_addr = 5'd2; mem_wb_wen = 1'b1;
        step(mk(EN_ALL, 3'b000, 2'd2, 2'd0, 0, 0, 0), "load_fwd_mem");

        // $3 in both EXE and MEM: EXE wins
        idle_inputs();
        id_rs_addr = 5'd3; id_rs_used = 1'b1; id_rt_addr = 5'd3; id_rt_used = 1'b1;
        exe_wb_addr = 5'd3; exe_wb_wen = 1'b1; mem_wb_addr = 5'd3; mem_wb_wen = 1'b1;
        step(mk(EN_ALL, 3'b000, 2'd1, 2'd1, 0, 0, 0), "fwd_exe_wins");
        id_rt_used = 1'b0;
        step(mk(EN_ALL, 3'b000, 2'd1, 2'd0, 0, 0, 0), "rt_unused");

        // $0 is never forwarded nor stalls on
        idle_inputs();
        id_rs_used = 1'b1; id_rt_used = 1'b1;
        exe_wb_wen = 1'b1; exe_mem_ren = 1'b1; mem_wb_wen = 1'b1;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "reg0_dest");

        idle_inputs();
        id_rs_addr = 5'd9; id_rs_used = 1'b1; id_rt_addr = 5'd7; id_rt_used = 1'b1;
        exe_wb_addr = 5'd4; exe_wb_wen = 1'b1; mem_wb_addr = 5'd7; mem_wb_wen = 1'b1;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd2, 0, 0, 0), "fwd_mem_rt");

        idle_inputs();
        id_rt_addr = 5'd6; id_rt_used = 1'b1; id_rs_addr = 5'd6;
        exe_wb_addr = 5'd6; exe_wb_wen = 1'b1; exe_mem_ren = 1'b1;
        step(mk(5'b00111, 3'b010, 2'd0, 2'd0, 0, 0, 0), "load_use_rt");
        ic_stall = 1'b1;
        step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 0, 0, 0), "ic_stall_over_hazard");

        // Invalidate completed by inv_done in the 5th INV_WAIT cycle
        idle_inputs();
        mem_inv_req = 1'b1; inv_done = 1'b1;
        step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 1, 0, 0), "inv_start");
        inv_done = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exc_req = (i == 2); dc_stall = (i == 2);
            step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 0, 0, 0), "inv_wait_frozen");
        end
        exc_req = 1'b0; dc_stall = 1'b0; inv_done = 1'b1;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "inv_done_release");
        idle_inputs();
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_after_inv");

        // Invalidate timeout: error in the 256th INV_WAIT cycle
        mem_inv_req = 1'b1;
        step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 1, 0, 0), "inv_start_to");
        for (int i = 0; i < 255; i++) begin
            step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 0, 0, 0), "inv_wait_to");
        end
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 1, 0), "inv_timeout");
        mem_inv_req = 1'b0;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_after_timeout");

        // Exception beats dc_stall and load-use; two FLUSH cycles follow
        id_rs_addr = 5'd2; id_rs_used = 1'b1;
        exe_wb_addr = 5'd2; exe_wb_wen = 1'b1; exe_mem_ren = 1'b1;
        dc_stall = 1'b1; exc_req = 1'b1;
        step(mk(5'b10001, 3'b111, 2'd0, 2'd0, 0, 0, 1), "exc_priority");
        idle_inputs();
        exc_req = 1'b1;
        step(mk(5'b00001, 3'b111, 2'd0, 2'd0, 0, 0, 0), "flush_1");
        step(mk(5'b00001, 3'b111, 2'd0, 2'd0, 0, 0, 0), "flush_2");
        exc_req = 1'b0;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_after_flush");

        // Reset while in INV_WAIT
        mem_inv_req = 1'b1;
        step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 1, 0, 0), "inv_start_rst");
        step(mk(EN_NONE, 3'b000, 2'd0, 2'd0, 0, 0, 0), "inv_wait_rst");
        rst = 1'b1;
        step(mk(EN_NONE, 3'b111, 2'd0, 2'd0, 0, 0, 0), "rst_in_inv_wait");
        rst = 1'b0; mem_inv_req = 1'b0;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_after_rst_inv");

        // Reset while in FLUSH
        exc_req = 1'b1;
        step(mk(5'b10001, 3'b111, 2'd0, 2'd0, 0, 0, 1), "exc_for_rst");
        exc_req = 1'b0;
        step(mk(5'b00001, 3'b111, 2'd0, 2'd0, 0, 0, 0), "flush_before_rst");
        rst = 1'b1;
        step(mk(EN_NONE, 3'b111, 2'd0, 2'd0, 0, 0, 0), "rst_in_flush");
        rst = 1'b0;
        step(mk(EN_ALL, 3'b000, 2'd0, 2'd0, 0, 0, 0), "run_after_rst_flush");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
